// File: rtl/srrc_pkg.sv
// Shared definitions for the SRRC transmit interpolator and its receive mate.
// Holds the filter geometry, the 21-tap 0s18 prototype (only the first half is
// stored, the rest is mirrored), the Gray 4-ASK level map and the 18-bit
// saturating output conversion.
package srrc_pkg;

   localparam int NTAPS = 21;
   localparam int SPS   = 4;
   localparam int NHIST = (NTAPS + SPS - 1) / SPS;   // symbol history depth
   localparam int PHW   = $clog2(SPS);
   localparam int LVL1  = 32768;                     // 0.25 in 1s17
   localparam int LVL3  = 98304;                     // 0.75 in 1s17

   // h[0..10]; h[k] = h[NTAPS-1-k] supplies the remainder
   localparam int H_HALF [0:10] = '{4094, 5900, 3326, -3449, -10679, -12462,
                                    -4029, 14915, 38991, 59143, 66990};

   typedef logic signed [17:0] level_t;   // 1s17 sample / symbol level
   typedef logic signed [18:0] coef_t;    // 0s18 coefficient plus sign
   typedef logic signed [36:0] prod_t;    // level x coefficient
   typedef logic signed [39:0] acc_t;     // full-precision accumulator

   // Tap lookup; indices outside 0..NTAPS-1 read as zero so short polyphase
   // branches simply contribute nothing.
   function automatic coef_t tap(input int idx);
      int j;
      if (idx < 0 || idx > NTAPS - 1) return '0;
      j = (idx > NTAPS - 1 - idx) ? (NTAPS - 1 - idx) : idx;
      return coef_t'(H_HALF[j]);
   endfunction

   function automatic level_t gray_map(input logic [1:0] sym);
      case (sym)
         2'b00:   return level_t'(-LVL3);
         2'b01:   return level_t'(-LVL1);
         2'b11:   return level_t'(LVL1);
         default: return level_t'(LVL3);
      endcase
   endfunction

   // Floor-scale the accumulator back to 1s17 and clamp to the 18-bit range.
   function automatic level_t sat18(input acc_t a);
      acc_t s;
      s = a >>> 18;
      if (s > acc_t'(131071))  return level_t'(131071);
      if (s < acc_t'(-131072)) return level_t'(-131072);
      return level_t'(s);
   endfunction

endpackage

// File: rtl/srrc_tx_filt_if.sv
// Symbol-in / sample-out bundle of the SRRC transmit interpolator.
//   samp_en   : output-sample strobe (source side)
//   sym_in    : Gray 4-ASK symbol, sym_valid qualifies it
//   sym_ready : symbol is taken this clk when sym_valid is high
//   y/y_valid : shaped 1s17 sample and its one-clk update pulse
//   underrun  : sticky flag, a ready found no valid symbol
interface srrc_tx_filt_if;
   import srrc_pkg::*;

   logic       samp_en;
   logic [1:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;
   level_t     y;
   logic       y_valid;
   logic       underrun;

   modport master (output samp_en, sym_in, sym_valid,
                   input  sym_ready, y, y_valid, underrun);
   modport slave  (input  samp_en, sym_in, sym_valid,
                   output sym_ready, y, y_valid, underrun);
endinterface

// File: rtl/srrc_tx_mapper.sv
// Gray 4-ASK symbol to signed 1s17 level, purely combinational.
//   sym   : 2-bit Gray symbol
//   level : mapped level (+/-LVL1, +/-LVL3)
module srrc_tx_mapper
   import srrc_pkg::*;
(
   input  logic [1:0] sym,
   output level_t     level
);
   assign level = gray_map(sym);
endmodule

// File: rtl/srrc_tx_filt.sv
// SRRC polyphase pulse-shaping interpolator, SPS output samples per symbol.
//   clk    : system clock
//   reset  : asynchronous active-high, clears all state
//   bus    : slave side of srrc_tx_filt_if (symbol handshake, sample output,
//            underrun flag)
// One multiplier per history entry; the phase counter picks which polyphase
// branch of the prototype feeds them. Products are registered on the strobe
// edge, the sum is saturated into y on the following edge.
module srrc_tx_filt
   import srrc_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   srrc_tx_filt_if.slave bus
);

   logic [PHW-1:0] phase_reg;
   logic [PHW-1:0] phase_next;
   level_t         hist_reg  [NHIST];
   level_t         hist_next [NHIST];
   coef_t          coef      [NHIST];
   prod_t          prod_reg  [NHIST];
   logic           pvalid_reg;
   acc_t           acc;
   level_t         y_reg;
   logic           y_valid_reg;
   logic           underrun_reg;
   level_t         new_level;
   logic           ready;

   srrc_tx_mapper u_mapper (
      .sym   (bus.sym_in),
      .level (new_level)
   );

   assign ready         = bus.samp_en & (phase_reg == '0);
   assign bus.sym_ready = ready;
   assign bus.y         = y_reg;
   assign bus.y_valid   = y_valid_reg;
   assign bus.underrun  = underrun_reg;

   assign phase_next = (phase_reg == PHW'(SPS - 1)) ? '0 : phase_reg + 1'b1;

   // Post-shift history: the products for the current strobe must already
   // see the symbol taken on this same edge.
   genvar gi;
   generate
      for (gi = 0; gi < NHIST; gi++) begin : g_hist
         if (gi == 0) begin : g_head
            assign hist_next[gi] = !ready        ? hist_reg[gi] :
                                   bus.sym_valid ? new_level    : '0;
         end else begin : g_tail
            assign hist_next[gi] = ready ? hist_reg[gi-1] : hist_reg[gi];
         end
         assign coef[gi] = tap(SPS * gi + int'(phase_reg));
      end
   endgenerate

   always_comb begin
      acc = '0;
      for (int k = 0; k < NHIST; k++) begin
         acc = acc + acc_t'(prod_reg[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_reg    <= '0;
         pvalid_reg   <= 1'b0;
         y_reg        <= '0;
         y_valid_reg  <= 1'b0;
         underrun_reg <= 1'b0;
         for (int k = 0; k < NHIST; k++) begin
            hist_reg[k] <= '0;
            prod_reg[k] <= '0;
         end
      end else begin
         pvalid_reg  <= bus.samp_en;
         y_valid_reg <= pvalid_reg;
         if (pvalid_reg) y_reg <= sat18(acc);
         if (ready && !bus.sym_valid) underrun_reg <= 1'b1;
         if (bus.samp_en) begin
            phase_reg <= phase_next;
            for (int k = 0; k < NHIST; k++) begin
               hist_reg[k] <= hist_next[k];
               prod_reg[k] <= prod_t'(coef[k]) * prod_t'(hist_next[k]);
            end
         end
      end
   end

endmodule

// File: tb/tb_srrc_tx_filt.sv
module tb_srrc_tx_filt;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   passed;

   srrc_tx_filt_if bus ();

   srrc_tx_filt dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference prototype, written out in full
   int hb [21] = '{4094, 5900, 3326, -3449, -10679, -12462, -4029, 14915, 38991,
                   59143, 66990, 59143, 38991, 14915, -4029, -12462, -10679,
                   -3449, 3326, 5900, 4094};

   logic [1:0] st_sym [$];
   bit         st_val [$];
   int         got_q  [$];
   int         got_cyc[$];
   int         en_cyc [$];
   bit         rdy_q  [$];
   int         exp_q  [$];
   int         save_q [$];

   always @(negedge clk) begin
      if (bus.y_valid === 1'b1) begin
         got_q.push_back(int'(bus.y));
         got_cyc.push_back(cyc);
      end
   end

   function automatic longint lvl(input logic [1:0] s);
      case (s)
         2'b00:   return -98304;
         2'b01:   return -32768;
         2'b11:   return 32768;
         default: return 98304;
      endcase
   endfunction

   // Zero-stuff the symbol stream at SPS and convolve with the full prototype.
   task automatic build_exp();
      longint u [$];
      int n;
      exp_q.delete();
      n = st_sym.size() * 4;
      for (int i = 0; i < n; i++)
         u.push_back(((i % 4) == 0 && st_val[i/4]) ? lvl(st_sym[i/4]) : 64'sd0);
      for (int i = 0; i < n; i++) begin
         longint acc;
         longint s;
         acc = 0;
         for (int m = 0; m < 21; m++)
            if (i - m >= 0) acc += longint'(hb[m]) * u[i-m];
         s = acc >>> 18;
         if (s > 131071) s = 131071;
         if (s < -131072) s = -131072;
         exp_q.push_back(int'(s));
      end
   endtask

   task automatic clear_logs();
      got_q.delete();
      got_cyc.delete();
      en_cyc.delete();
      rdy_q.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #1;
      bus.samp_en   = 1'b0;
      bus.sym_valid = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      clear_logs();
   endtask

   // One strobe every 'gap' clks; off-phase and idle clks carry junk symbols.
   task automatic drive(input int gap);
      int n;
      n = st_sym.size() * 4;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.samp_en = 1'b1;
         if ((i % 4) == 0) begin
            bus.sym_in    = st_sym[i/4];
            bus.sym_valid = st_val[i/4];
         end else begin
            bus.sym_in    = 2'($urandom);
            bus.sym_valid = 1'($urandom);
         end
         en_cyc.push_back(cyc);
         #1;
         rdy_q.push_back(bus.sym_ready);
         for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            bus.samp_en   = 1'b0;
            bus.sym_in    = 2'($urandom);
            bus.sym_valid = 1'($urandom);
         end
      end
      @(negedge clk);
      bus.samp_en   = 1'b0;
      bus.sym_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic load_impulse(input logic [1:0] s);
      st_sym = '{s, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      st_val = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endtask

   task automatic test_reset();
      st_sym = '{2'b10, 2'b11};
      st_val = '{1'b0, 1'b1};
      drive(1);
      apply_reset();
      checks++; if (bus.y !== 18'sd0) $display("FAIL reset_y got %0d want 0", bus.y); else passed++;
      checks++; if (bus.y_valid !== 1'b0) $display("FAIL reset_y_valid got %b want 0", bus.y_valid); else passed++;
      checks++; if (bus.underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", bus.underrun); else passed++;
      checks++; if (bus.sym_ready !== 1'b0) $display("FAIL reset_sym_ready got %b want 0", bus.sym_ready); else passed++;
      @(negedge clk);
      bus.samp_en = 1'b1;
      #1;
      checks++; if (bus.sym_ready !== 1'b1) $display("FAIL first_ready got %b want 1", bus.sym_ready); else passed++;
      @(negedge clk);
      bus.samp_en = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_impulse();
      apply_reset();
      load_impulse(2'b10);
      drive(1);
      build_exp();
      checks++; if (got_q.size() !== exp_q.size()) $display("FAIL impulse_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL impulse_y[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
         else passed++;
      end
      checks++; if (got_q[0] !== 1535) $display("FAIL impulse_y0 got %0d want 1535", got_q[0]); else passed++;
      checks++; if (got_q[1] !== 2212) $display("FAIL impulse_y1 got %0d want 2212", got_q[1]); else passed++;
      checks++; if (got_q[3] !== -1294) $display("FAIL impulse_y3 got %0d want -1294", got_q[3]); else passed++;
      checks++; if (got_q[10] !== 25121) $display("FAIL impulse_y10 got %0d want 25121", got_q[10]); else passed++;
      checks++; if (got_q[20] !== 1535) $display("FAIL impulse_y20 got %0d want 1535", got_q[20]); else passed++;
      checks++; if (got_q[21] !== 0) $display("FAIL impulse_y21 got %0d want 0", got_q[21]); else passed++;
      checks++; if (bus.underrun !== 1'b1) $display("FAIL impulse_underrun got %b want 1", bus.underrun); else passed++;
      $display("test_impulse done: %0d samples", got_q.size());
   endtask

   task automatic test_gray_floor();
      apply_reset();
      load_impulse(2'b00);
      drive(1);
      checks++; if (got_q[10] !== -25122) $display("FAIL gray00_y10 got %0d want -25122", got_q[10]); else passed++;
      checks++; if (got_q[0] !== -1536) $display("FAIL gray00_y0 got %0d want -1536", got_q[0]); else passed++;
      apply_reset();
      load_impulse(2'b01);
      drive(1);
      build_exp();
      checks++; if (got_q[10] !== -8374) $display("FAIL gray01_y10 got %0d want -8374", got_q[10]); else passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL gray01_y[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
         else passed++;
      end
      $display("test_gray_floor done");
   endtask

   task automatic test_dc();
      int pv [4] = '{8101, 8005, 8198, 8005};
      apply_reset();
      st_sym.delete();
      st_val.delete();
      for (int i = 0; i < 10; i++) begin
         st_sym.push_back(2'b11);
         st_val.push_back(1'b1);
      end
      drive(1);
      for (int i = 24; i < 40; i++) begin
         checks++;
         if (got_q[i] !== pv[i%4]) $display("FAIL dc_y[%0d] got %0d want %0d", i, got_q[i], pv[i%4]);
         else passed++;
      end
      checks++; if (bus.underrun !== 1'b0) $display("FAIL dc_underrun got %b want 0", bus.underrun); else passed++;
      $display("test_dc done");
   endtask

   task automatic test_timing();
      apply_reset();
      st_sym.delete();
      st_val.delete();
      for (int i = 0; i < 8; i++) begin
         st_sym.push_back(2'($urandom));
         st_val.push_back(1'b1);
      end
      build_exp();
      drive(1);
      save_q = got_q;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL dense_y[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
         else passed++;
      end
      apply_reset();
      drive(3);
      checks++; if (got_q.size() !== save_q.size()) $display("FAIL sparse_count got %0d want %0d", got_q.size(), save_q.size()); else passed++;
      for (int i = 0; i < save_q.size(); i++) begin
         checks++;
         if (got_q[i] !== save_q[i]) $display("FAIL sparse_vs_dense[%0d] got %0d want %0d", i, got_q[i], save_q[i]);
         else passed++;
      end
      for (int i = 0; i < en_cyc.size(); i++) begin
         checks++;
         if (got_cyc[i] - en_cyc[i] !== 2) $display("FAIL latency[%0d] got %0d want 2", i, got_cyc[i] - en_cyc[i]);
         else passed++;
         checks++;
         if (rdy_q[i] !== ((i % 4) == 0)) $display("FAIL ready[%0d] got %b want %b", i, rdy_q[i], (i % 4) == 0);
         else passed++;
      end
      $display("test_timing done");
   endtask

   task automatic test_midstream();
      apply_reset();
      st_sym.delete();
      st_val.delete();
      for (int i = 0; i < 6; i++) begin
         st_sym.push_back(2'($urandom));
         st_val.push_back(i != 2);
      end
      build_exp();
      drive(1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL gap_y[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
         else passed++;
      end
      checks++; if (bus.underrun !== 1'b1) $display("FAIL gap_underrun got %b want 1", bus.underrun); else passed++;
      // start a new symbol with a full-scale level, then reset two phases in
      @(negedge clk);
      bus.samp_en = 1'b1; bus.sym_in = 2'b10; bus.sym_valid = 1'b1;
      @(negedge clk);
      bus.sym_valid = 1'b0;
      @(negedge clk);
      bus.samp_en = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      checks++; if (bus.y !== 18'sd0) $display("FAIL midreset_y got %0d want 0", bus.y); else passed++;
      checks++; if (bus.y_valid !== 1'b0) $display("FAIL midreset_y_valid got %b want 0", bus.y_valid); else passed++;
      checks++; if (bus.underrun !== 1'b0) $display("FAIL midreset_underrun got %b want 0", bus.underrun); else passed++;
      #1;
      reset = 1'b0;
      clear_logs();
      load_impulse(2'b10);
      build_exp();
      drive(1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL post_reset_y[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
         else passed++;
      end
      checks++; if (got_q[10] !== 25121) $display("FAIL post_reset_y10 got %0d want 25121", got_q[10]); else passed++;
      $display("test_midstream done");
   endtask

   initial begin
      checks = 0;
      passed = 0;
      reset  = 1'b1;
      bus.samp_en   = 1'b0;
      bus.sym_in    = 2'b00;
      bus.sym_valid = 1'b0;
      #2;
      reset = 1'b0;
      test_reset();
      test_impulse();
      test_gray_floor();
      test_dc();
      test_timing();
      test_midstream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
